// File: rtl/id_ctrl_stage.sv
// Instruction-decode control stage: decodes a MIPS-style instruction into a registered
// control word, with load-use interlock, flush, and a SYSCALL drain/halt sequence.
module id_ctrl_stage #(
    parameter int ALU_OP_W     = 4,
    parameter int EN_VSHIFT    = 0,
    parameter int EN_BYTE_MEM  = 0,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                ex_stall,
    input  logic                flush,
    input  logic                halt_go,
    output logic                out_valid,
    output logic                beq,
    output logic                bne,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic                alu_src_b,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                signed_ext,
    output logic                jal,
    output logic                jmp,
    output logic                jr,
    output logic                syscall,
    output logic                shamt_var,
    output logic                illegal,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          ram_sel,
    output logic                mem_unsigned,
    output logic                halted
);

    typedef struct packed {
        logic       beq, bne, mem_to_reg, mem_write, alu_src_b, reg_write, reg_dst;
        logic       signed_ext, jal, jmp, jr, syscall, shamt_var, illegal;
        logic [3:0] alu_op;
        logic [1:0] ram_sel;
        logic       mem_unsigned;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    logic [5:0] op, func;
    logic [4:0] rs, rt;
    assign op   = instr[31:26];
    assign rs   = instr[25:21];
    assign rt   = instr[20:16];
    assign func = instr[5:0];

    ctrl_t      dec, ctrl_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] ld_rt_q;
    logic       r_alu, uses_rt, hazard, load;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec   = '0;
        r_alu = 1'b0;
        case (op)
            6'd0: begin
                case (func)
                    6'd0:  begin r_alu = 1'b1; dec.alu_op = 4'b0000; end
                    6'd2:  begin r_alu = 1'b1; dec.alu_op = 4'b0010; end
                    6'd3:  begin r_alu = 1'b1; dec.alu_op = 4'b0001; end
                    6'd4, 6'd6, 6'd7: begin
                        if (EN_VSHIFT != 0) begin
                            r_alu         = 1'b1;
                            dec.shamt_var = 1'b1;
                            dec.alu_op    = (func == 6'd4) ? 4'b0000 :
                                            (func == 6'd6) ? 4'b0010 : 4'b0001;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    6'd8:  dec.jr = 1'b1;
                    6'd12: dec.syscall = 1'b1;
                    6'd32, 6'd33: begin r_alu = 1'b1; dec.alu_op = 4'b0101; end
                    6'd34: begin r_alu = 1'b1; dec.alu_op = 4'b0110; end
                    6'd36: begin r_alu = 1'b1; dec.alu_op = 4'b0111; end
                    6'd37: begin r_alu = 1'b1; dec.alu_op = 4'b1000; end
                    6'd39: begin r_alu = 1'b1; dec.alu_op = 4'b1010; end
                    6'd42: begin r_alu = 1'b1; dec.alu_op = 4'b1011; end
                    6'd43: begin r_alu = 1'b1; dec.alu_op = 4'b1100; end
                    default: dec.illegal = 1'b1;
                endcase
                dec.reg_dst   = r_alu;
                dec.reg_write = r_alu;
            end
            6'd2:  dec.jmp = 1'b1;
            6'd3:  begin dec.jal = 1'b1; dec.reg_write = 1'b1; end
            6'd4:  begin dec.beq = 1'b1; dec.signed_ext = 1'b1; end
            6'd5:  begin dec.bne = 1'b1; dec.signed_ext = 1'b1; end
            6'd8:  begin dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; dec.signed_ext = 1'b1; end
            6'd9:  begin dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
            6'd10: begin dec.alu_op = 4'b1011; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; dec.signed_ext = 1'b1; end
            6'd12: begin dec.alu_op = 4'b0111; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
            6'd13: begin dec.alu_op = 4'b1000; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; end
            6'd35: begin
                dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.signed_ext = 1'b1;
                dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
            end
            6'd43: begin dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.signed_ext = 1'b1; dec.mem_write = 1'b1; end
            6'd32, 6'd36: begin
                if (EN_BYTE_MEM != 0) begin
                    dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.signed_ext = 1'b1;
                    dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                    dec.ram_sel = 2'b11; dec.mem_unsigned = (op == 6'd36);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            6'd40: begin
                if (EN_BYTE_MEM != 0) begin
                    dec.alu_op = 4'b0101; dec.alu_src_b = 1'b1; dec.signed_ext = 1'b1;
                    dec.mem_write = 1'b1; dec.ram_sel = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // rt is a source operand only for R-type, branches and stores; rs is compared for everything.
    assign uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43) ||
                     ((EN_BYTE_MEM != 0) && (op == 6'd40));
    assign hazard  = in_valid && ctrl_q.mem_to_reg && (ld_rt_q != 5'd0) &&
                     ((rs == ld_rt_q) || (uses_rt && (rt == ld_rt_q)));
    assign in_ready = (state_q == RUN) && !ex_stall && !flush && !hazard;
    assign load     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: if (load && dec.syscall) begin
                state_d = DRAIN;
                cnt_d   = 4'd0;
            end
            DRAIN: if (cnt_q == DRAIN_LAST) begin
                state_d = HALTED;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            HALTED: if (halt_go) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            ld_rt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                ctrl_q    <= '0;
                out_valid <= 1'b0;
            end else if (!ex_stall) begin
                if (load) begin
                    ctrl_q    <= dec;
                    out_valid <= 1'b1;
                    ld_rt_q   <= rt;
                end else begin
                    ctrl_q    <= '0;
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign beq          = ctrl_q.beq;
    assign bne          = ctrl_q.bne;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign mem_write    = ctrl_q.mem_write;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign reg_write    = ctrl_q.reg_write;
    assign reg_dst      = ctrl_q.reg_dst;
    assign signed_ext   = ctrl_q.signed_ext;
    assign jal          = ctrl_q.jal;
    assign jmp          = ctrl_q.jmp;
    assign jr           = ctrl_q.jr;
    assign syscall      = ctrl_q.syscall;
    assign shamt_var    = ctrl_q.shamt_var;
    assign illegal      = ctrl_q.illegal;
    assign alu_op       = ALU_OP_W'(ctrl_q.alu_op);
    assign ram_sel      = ctrl_q.ram_sel;
    assign mem_unsigned = ctrl_q.mem_unsigned;
    assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: base-config instance (a_*) and an instance with
// variable shifts and byte memory ops enabled (b_*), driven by the same stimulus.
module tb_id_ctrl_stage;

    localparam logic [31:0] I_ADD   = 32'h0022_1820; // ADD  $3,$1,$2
    localparam logic [31:0] I_LW    = 32'h8C25_0000; // LW   $5,0($1)
    localparam logic [31:0] I_ADD6  = 32'h00A2_3020; // ADD  $6,$5,$2
    localparam logic [31:0] I_SRAV  = 32'h0022_1807; // SRAV $3,$2,$1
    localparam logic [31:0] I_LBU   = 32'h9027_0000; // LBU  $7,0($1)
    localparam logic [31:0] I_ORI   = 32'h3404_0005; // ORI  $4,$0,5
    localparam logic [31:0] I_SUBU  = 32'h0022_1823; // SUBU (not decoded)
    localparam logic [31:0] I_BEQ   = 32'h1022_0004; // BEQ  $1,$2,4
    localparam logic [31:0] I_SYS   = 32'h0000_000C; // SYSCALL

    logic        clk = 1'b0;
    logic        rst_n, in_valid, ex_stall, flush, halt_go;
    logic [31:0] instr;

    logic       a_in_ready, a_out_valid, a_beq, a_bne, a_mem_to_reg, a_mem_write, a_alu_src_b;
    logic       a_reg_write, a_reg_dst, a_signed_ext, a_jal, a_jmp, a_jr, a_syscall, a_shamt_var;
    logic       a_illegal, a_mem_unsigned, a_halted;
    logic [3:0] a_alu_op;
    logic [1:0] a_ram_sel;

    logic       b_in_ready, b_out_valid, b_beq, b_bne, b_mem_to_reg, b_mem_write, b_alu_src_b;
    logic       b_reg_write, b_reg_dst, b_signed_ext, b_jal, b_jmp, b_jr, b_syscall, b_shamt_var;
    logic       b_illegal, b_mem_unsigned, b_halted;
    logic [3:0] b_alu_op;
    logic [1:0] b_ram_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ctrl_stage u_dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(a_in_ready),
        .ex_stall(ex_stall), .flush(flush), .halt_go(halt_go), .out_valid(a_out_valid),
        .beq(a_beq), .bne(a_bne), .mem_to_reg(a_mem_to_reg), .mem_write(a_mem_write),
        .alu_src_b(a_alu_src_b), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
        .signed_ext(a_signed_ext), .jal(a_jal), .jmp(a_jmp), .jr(a_jr), .syscall(a_syscall),
        .shamt_var(a_shamt_var), .illegal(a_illegal), .alu_op(a_alu_op), .ram_sel(a_ram_sel),
        .mem_unsigned(a_mem_unsigned), .halted(a_halted)
    );

    id_ctrl_stage #(.EN_VSHIFT(1), .EN_BYTE_MEM(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(b_in_ready),
        .ex_stall(ex_stall), .flush(flush), .halt_go(halt_go), .out_valid(b_out_valid),
        .beq(b_beq), .bne(b_bne), .mem_to_reg(b_mem_to_reg), .mem_write(b_mem_write),
        .alu_src_b(b_alu_src_b), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .signed_ext(b_signed_ext), .jal(b_jal), .jmp(b_jmp), .jr(b_jr), .syscall(b_syscall),
        .shamt_var(b_shamt_var), .illegal(b_illegal), .alu_op(b_alu_op), .ram_sel(b_ram_sel),
        .mem_unsigned(b_mem_unsigned), .halted(b_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0; halt_go = 1'b0;
        instr = 32'h0;
        #2;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_halted",    32'(a_halted),    32'd0);
        check("rst_alu_op",    32'(a_alu_op),    32'd0);
        #1 rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(a_in_ready), 32'd1);
        tick();

        in_valid = 1'b1; instr = I_ADD;
        tick();
        check("add_alu_op",    32'(a_alu_op),    32'h5);
        check("add_reg_dst",   32'(a_reg_dst),   32'd1);
        check("add_reg_write", 32'(a_reg_write), 32'd1);
        check("add_out_valid", 32'(a_out_valid), 32'd1);

        instr = I_LW;
        tick();
        check("lw_mem_to_reg", 32'(a_mem_to_reg), 32'd1);
        check("lw_alu_src_b",  32'(a_alu_src_b),  32'd1);
        check("lw_ram_sel",    32'(a_ram_sel),    32'd0);

        instr = I_ADD6;
        #1 check("lu_in_ready_low", 32'(a_in_ready), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(a_out_valid), 32'd0);
        check("lu_bubble_rw",    32'(a_reg_write), 32'd0);
        check("lu_in_ready_hi",  32'(a_in_ready),  32'd1);
        tick();
        check("lu_add_alu_op", 32'(a_alu_op),    32'h5);
        check("lu_add_valid",  32'(a_out_valid), 32'd1);

        instr = I_SRAV;
        tick();
        check("srav0_illegal",   32'(a_illegal),   32'd1);
        check("srav0_reg_write", 32'(a_reg_write), 32'd0);
        check("srav1_alu_op",    32'(b_alu_op),    32'h1);
        check("srav1_shamt_var", 32'(b_shamt_var), 32'd1);
        check("srav1_reg_dst",   32'(b_reg_dst),   32'd1);

        instr = I_LBU;
        tick();
        check("lbu0_illegal",  32'(a_illegal),      32'd1);
        check("lbu1_ram_sel",  32'(b_ram_sel),      32'h3);
        check("lbu1_unsigned", 32'(b_mem_unsigned), 32'd1);
        check("lbu1_mem2reg",  32'(b_mem_to_reg),   32'd1);

        instr = I_ORI;
        tick();
        check("ori_alu_op",    32'(a_alu_op),    32'h8);
        check("ori_alu_src_b", 32'(a_alu_src_b), 32'd1);
        check("ori1_alu_op",   32'(b_alu_op),    32'h8);

        ex_stall = 1'b1; instr = I_ADD;
        #1 check("stall_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        check("stall1_alu_op", 32'(a_alu_op), 32'h8);
        tick();
        check("stall2_alu_op", 32'(a_alu_op),    32'h8);
        check("stall2_valid",  32'(a_out_valid), 32'd1);
        flush = 1'b1;
        tick();
        check("flush_valid",  32'(a_out_valid), 32'd0);
        check("flush_alu_op", 32'(a_alu_op),    32'h0);
        flush = 1'b0; ex_stall = 1'b0;

        instr = I_SUBU;
        tick();
        check("subu_illegal", 32'(a_illegal),   32'd1);
        check("subu_valid",   32'(a_out_valid), 32'd1);
        check("subu_rw",      32'(a_reg_write), 32'd0);

        instr = I_BEQ;
        tick();
        check("beq_beq",        32'(a_beq),        32'd1);
        check("beq_signed_ext", 32'(a_signed_ext), 32'd1);
        check("beq_alu_op",     32'(a_alu_op),     32'h0);

        in_valid = 1'b0;
        tick();
        check("novalid_bubble", 32'(a_out_valid), 32'd0);

        in_valid = 1'b1; instr = I_SYS;
        tick();
        check("sys_syscall", 32'(a_syscall),   32'd1);
        check("sys_valid",   32'(a_out_valid), 32'd1);
        instr = I_ADD;
        #1 check("drain_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        check("drain1_valid",  32'(a_out_valid), 32'd0);
        check("drain1_halted", 32'(a_halted),    32'd0);
        halt_go = 1'b1;
        tick();
        halt_go = 1'b0;
        check("drain2_halted", 32'(a_halted), 32'd0);
        tick();
        check("halted_set",      32'(a_halted),   32'd1);
        check("halted_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        check("halted_hold", 32'(a_halted), 32'd1);
        halt_go = 1'b1;
        tick();
        halt_go = 1'b0;
        check("resume_halted", 32'(a_halted), 32'd0);
        #1 check("resume_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        check("resume_add_alu_op", 32'(a_alu_op),    32'h5);
        check("resume_add_valid",  32'(a_out_valid), 32'd1);

        instr = I_SYS;
        tick();
        check("sys2_syscall", 32'(a_syscall), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_syscall", 32'(a_syscall),   32'd0);
        check("arst_valid",   32'(a_out_valid), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_halted",   32'(a_halted),   32'd0);
        check("arst_in_ready", 32'(a_in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
